flash_cmd_seq: RTL and testbench

Command sequencer placed directly upstream of the flash bus interface. It turns single host requests into the 16-bit command sequences used by Intel-style (StrataFlash) parts: read array, word program, block erase and read status. It drives the interface's 24-bit bus master port, one transaction at a time, and polls the status register until the write state machine is ready. It reports the read word, the final status byte and error/timeout flags.

---
 rtl/flash_cmd_seq_if.sv | 31 +++
 rtl/flash_cmd_seq.sv | 178 +++++++++++++++++
 tb/tb_flash_cmd_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_cmd_seq_if.sv
// Host request/response and 24-bit flash bus-master signals of the StrataFlash command sequencer.
interface flash_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [7:0]  rsp_status;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [23:0] bus_address;
  logic [31:0] bus_data_i;
  logic [31:0] bus_data_o;
  logic        bus_read;
  logic        bus_write;
  logic        bus_stall;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_data_o, bus_stall,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_err, rsp_timeout,
           bus_address, bus_data_i, bus_read, bus_write
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_data_o, bus_stall,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_err, rsp_timeout,
           bus_address, bus_data_i, bus_read, bus_write
  );
endinterface

// File: rtl/flash_cmd_seq.sv
// Expands one host request into a StrataFlash command sequence and polls status until the WSM is ready.
// First strobe one cycle after accept; each transaction holds while bus_stall=1, then one strobe-low gap.
module flash_cmd_seq #(
  parameter int unsigned POLL_MAX  = 65535,
  parameter int unsigned POLL_WAIT = 16
) (
  input  logic            clk_bus,
  input  logic            rst,
  flash_cmd_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CMD1, CMD2, SR_CMD, WAIT, SR_RD, CLR, ARRAY, DONE
  } state_t;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_PROG = 2'b01;
  localparam logic [1:0] OP_STAT = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [15:0] word_q, word_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  status_q, status_d;
  logic        err_q, err_d, tmo_q, tmo_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [16:0] poll_next;
  logic        unused_hi;

  assign unused_hi = ^bus.bus_data_o[31:16];

  function automatic logic [15:0] cmd_word(state_t s, logic [1:0] op, logic [15:0] wd);
    case (s)
      CMD1:    cmd_word = (op == OP_PROG) ? 16'h0040 : 16'h0020;
      CMD2:    cmd_word = (op == OP_PROG) ? wd : 16'h00D0;
      SR_CMD:  cmd_word = 16'h0070;
      CLR:     cmd_word = 16'h0050;
      ARRAY:   cmd_word = 16'h00FF;
      default: cmd_word = 16'h0000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    poll_cnt_d = poll_cnt_q;
    wait_cnt_d = wait_cnt_q;
    poll_next  = {1'b0, poll_cnt_q} + 17'd1;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = bus.cmd_op;
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          rdata_d    = '0;
          status_d   = '0;
          err_d      = 1'b0;
          tmo_d      = 1'b0;
          poll_cnt_d = '0;
          wait_cnt_d = '0;
          case (bus.cmd_op)
            OP_READ: state_d = ARRAY;
            OP_STAT: state_d = SR_CMD;
            default: state_d = CMD1;
          endcase
          // Every sequence opens with a write, launched straight from the accept edge.
          wr_d   = 1'b1;
          word_d = cmd_word(state_d, bus.cmd_op, bus.cmd_wdata);
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (wait_cnt_q == 8'(POLL_WAIT - 1)) begin
          wait_cnt_d = '0;
          state_d    = SR_RD;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (!rd_q && !wr_q) begin
          rd_d   = (state_q == SR_RD);
          wr_d   = (state_q != SR_RD);
          word_d = cmd_word(state_q, op_q, wdata_q);
        end else if (!bus.bus_stall) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          case (state_q)
            CMD1:   state_d = CMD2;
            CMD2:   state_d = SR_CMD;
            SR_CMD: state_d = (op_q == OP_STAT) ? SR_RD : WAIT;
            CLR:    state_d = ARRAY;
            ARRAY:  state_d = (op_q == OP_READ) ? SR_RD : DONE;
            SR_RD: begin
              if (op_q == OP_READ) begin
                rdata_d = bus.bus_data_o[15:0];
                state_d = DONE;
              end else if (op_q == OP_STAT) begin
                status_d = bus.bus_data_o[7:0];
                state_d  = ARRAY;
              end else begin
                status_d   = bus.bus_data_o[7:0];
                poll_cnt_d = poll_next[15:0];
                if (bus.bus_data_o[7]) begin
                  err_d   = |(bus.bus_data_o[7:0] & 8'h3A);
                  state_d = err_d ? CLR : ARRAY;
                end else if (poll_next >= 17'(POLL_MAX)) begin
                  // Part still busy: no clear or read-array writes are safe.
                  tmo_d   = 1'b1;
                  state_d = DONE;
                end else begin
                  state_d = WAIT;
                end
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      word_q     <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      poll_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == DONE);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_status  = status_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.bus_address = {addr_q, 2'b00};
  assign bus.bus_data_i  = {16'h0000, word_q};
  assign bus.bus_read    = rd_q;
  assign bus.bus_write   = wr_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Directed and randomized checks of flash_cmd_seq against a transaction-list model of each command sequence.
module tb_flash_cmd_seq;
  localparam int POLL_MAX  = 4;
  localparam int POLL_WAIT = 16;

  typedef struct {
    bit          wr;
    logic [23:0] a;
    logic [15:0] d;
    int          cyc;
  } xact_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          stall_cfg = 0;
  xact_t       log_q[$];
  xact_t       exp_q[$];
  logic [15:0] rd_vals[$];
  logic [15:0] exp_rdata;
  logic [7:0]  exp_status;
  logic        exp_err;
  logic        exp_tmo;

  flash_cmd_seq_if bif();

  flash_cmd_seq #(.POLL_MAX(POLL_MAX), .POLL_WAIT(POLL_WAIT)) dut (
    .clk_bus(clk),
    .rst    (rst),
    .bus    (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Flash bus slave: per-transaction stall, hold/gap checks, read data from rd_vals.
  initial begin : flash_model
    bit          in_xfer;
    bit          just_done;
    int          left;
    logic [23:0] s_a;
    logic [31:0] s_d;
    logic        s_rd;
    logic [31:0] rnd;
    logic [15:0] v;
    in_xfer = 0; just_done = 0; left = 0;
    bif.bus_stall = 1'b0;
    bif.bus_data_o = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_xfer = 0;
        just_done = 0;
        bif.bus_stall = 1'b0;
      end else begin
        if (just_done) begin
          chk("gap_cycle", {31'b0, bif.bus_read | bif.bus_write}, 32'd0);
          just_done = 0;
        end
        if (bif.bus_read || bif.bus_write) begin
          chk("one_strobe", {31'b0, bif.bus_read & bif.bus_write}, 32'd0);
          if (!in_xfer) begin
            in_xfer = 1;
            s_a = bif.bus_address; s_d = bif.bus_data_i; s_rd = bif.bus_read;
            left = (stall_cfg < 0) ? int'($urandom_range(3)) : stall_cfg;
          end else begin
            chk("hold_addr", {8'h0, bif.bus_address}, {8'h0, s_a});
            chk("hold_data", bif.bus_data_i, s_d);
            chk("hold_read", {31'b0, bif.bus_read}, {31'b0, s_rd});
          end
          if (left > 0) begin
            bif.bus_stall = 1'b1;
            left--;
          end else begin
            bif.bus_stall = 1'b0;
            in_xfer = 0;
            just_done = 1;
            log_q.push_back('{wr: bif.bus_write, a: bif.bus_address, d: bif.bus_data_i[15:0], cyc: cyc});
            if (bif.bus_read) begin
              rnd = $urandom();
              v = 16'h0000;
              if (rd_vals.size() > 0) v = rd_vals.pop_front();
              bif.bus_data_o = {rnd[31:16], v};
            end
          end
        end else begin
          bif.bus_stall = ($urandom_range(1) == 1);
        end
      end
    end
  end

  function automatic void push_exp(input bit wr, input logic [23:0] a, input logic [15:0] d);
    xact_t x;
    x.wr = wr; x.a = a; x.d = d; x.cyc = 0;
    exp_q.push_back(x);
  endfunction

  function automatic logic [15:0] rv(input int i);
    rv = (i < rd_vals.size()) ? rd_vals[i] : 16'h0000;
  endfunction

  // Expected bus transactions and response derived from the command tables.
  function automatic void build_exp(input logic [1:0] op, input logic [21:0] addr, input logic [15:0] wd);
    logic [23:0] a;
    logic [7:0]  st;
    a = {addr, 2'b00};
    st = 8'h00;
    exp_q.delete();
    exp_rdata = 16'h0; exp_status = 8'h0; exp_err = 1'b0; exp_tmo = 1'b0;
    case (op)
      2'b00: begin
        push_exp(1, a, 16'h00FF); push_exp(0, a, 16'h0);
        exp_rdata = rv(0);
      end
      2'b11: begin
        push_exp(1, a, 16'h0070); push_exp(0, a, 16'h0); push_exp(1, a, 16'h00FF);
        st = rv(0) & 16'h00FF;
        exp_status = st;
      end
      default: begin
        push_exp(1, a, (op == 2'b01) ? 16'h0040 : 16'h0020);
        push_exp(1, a, (op == 2'b01) ? wd : 16'h00D0);
        push_exp(1, a, 16'h0070);
        for (int i = 0; i < POLL_MAX; i++) begin
          push_exp(0, a, 16'h0);
          st = rv(i) & 16'h00FF;
          if (st[7]) break;
          if (i == POLL_MAX - 1) exp_tmo = 1'b1;
        end
        exp_status = st;
        if (!exp_tmo) begin
          if ((st & 8'h3A) != 8'h00) begin
            exp_err = 1'b1;
            push_exp(1, a, 16'h0050);
          end
          push_exp(1, a, 16'h00FF);
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [21:0] addr, input logic [15:0] wd);
    int n;
    n = 0;
    while (!bif.cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_idle", {31'b0, bif.cmd_ready}, 32'd1);
    bif.cmd_valid = 1'b1; bif.cmd_op = op; bif.cmd_addr = addr; bif.cmd_wdata = wd;
    @(negedge clk);
    chk("first_strobe_wr", {31'b0, bif.bus_write}, 32'd1);
    chk("first_strobe_rd", {31'b0, bif.bus_read}, 32'd0);
    chk("first_addr", {8'h0, bif.bus_address}, {8'h0, addr, 2'b00});
    chk("first_data", bif.bus_data_i, {16'h0, exp_q[0].d});
    chk("busy_not_ready", {31'b0, bif.cmd_ready}, 32'd0);
    chk("rsp_cleared", {bif.rsp_rdata, bif.rsp_status, 6'b0, bif.rsp_err, bif.rsp_timeout}, 32'd0);
    // A request held during a busy sequence must be dropped, not queued.
    bif.cmd_op = ~op; bif.cmd_addr = ~addr;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [21:0] addr, input logic [15:0] wd, input int vstall);
    int n;
    int last_rd;
    n = 0; last_rd = -1;
    stall_cfg = vstall;
    build_exp(op, addr, wd);
    log_q.delete();
    issue(op, addr, wd);
    while (!bif.rsp_valid && n < 3000) begin @(negedge clk); n++; end
    chk("rsp_valid", {31'b0, bif.rsp_valid}, 32'd1);
    chk("rsp_rdata", {16'h0, bif.rsp_rdata}, {16'h0, exp_rdata});
    chk("rsp_status", {24'h0, bif.rsp_status}, {24'h0, exp_status});
    chk("rsp_err", {31'b0, bif.rsp_err}, {31'b0, exp_err});
    chk("rsp_timeout", {31'b0, bif.rsp_timeout}, {31'b0, exp_tmo});
    chk("xact_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("xact_dir", {31'b0, log_q[i].wr}, {31'b0, exp_q[i].wr});
      chk("xact_addr", {8'h0, log_q[i].a}, {8'h0, exp_q[i].a});
      if (exp_q[i].wr) chk("xact_wdata", {16'h0, log_q[i].d}, {16'h0, exp_q[i].d});
      else if (op == 2'b01 || op == 2'b10) begin
        if (last_rd >= 0) chk("poll_spacing", {31'b0, (log_q[i].cyc - last_rd) >= POLL_WAIT}, 32'd1);
        last_rd = log_q[i].cyc;
      end
    end
    if (log_q.size() > 0) chk("rsp_latency", cyc, log_q[log_q.size() - 1].cyc + 1);
    @(negedge clk);
    chk("rsp_pulse", {31'b0, bif.rsp_valid}, 32'd0);
    chk("ready_return", {31'b0, bif.cmd_ready}, 32'd1);
    chk("rsp_hold", {16'h0, bif.rsp_rdata}, {16'h0, exp_rdata});
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    bif.cmd_valid = 1'b0; bif.cmd_op = 2'b00; bif.cmd_addr = '0; bif.cmd_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_read", {31'b0, bif.bus_read}, 32'd0);
    chk("rst_write", {31'b0, bif.bus_write}, 32'd0);
    chk("rst_addr", {8'h0, bif.bus_address}, 32'd0);
    chk("rst_data", bif.bus_data_i, 32'd0);
    chk("rst_rsp", {bif.rsp_rdata, bif.rsp_status, bif.rsp_valid, 5'b0, bif.rsp_err, bif.rsp_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, bif.cmd_ready}, 32'd1);

    rd_vals = '{16'hBEEF};
    run_op(2'b00, 22'h12345, 16'h0000, 2);
    rd_vals = '{16'h0000, 16'h0000, 16'h0080};
    run_op(2'b01, 22'h00100, 16'h1234, -1);
    rd_vals = '{16'h0000, 16'h00A0};
    run_op(2'b10, 22'h3FFFFF, 16'h0000, -1);
    rd_vals = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_op(2'b01, 22'h0A5A5, 16'hCAFE, -1);
    rd_vals = '{16'h0084};
    run_op(2'b11, 22'h00ABC, 16'hFFFF, 5);

    // Reset while the sequencer waits between status polls.
    rd_vals.delete();
    stall_cfg = 0;
    build_exp(2'b01, 22'h2AAAA, 16'h5A5A);
    log_q.delete();
    issue(2'b01, 22'h2AAAA, 16'h5A5A);
    n = 0;
    while (log_q.size() < 3 && n < 200) begin @(negedge clk); n++; end
    chk("mid_poll_reached", log_q.size(), 32'd3);
    repeat (4) @(negedge clk);
    chk("in_wait_idle_bus", {31'b0, bif.bus_read | bif.bus_write}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", {30'b0, bif.bus_read, bif.bus_write}, 32'd0);
    chk("midrst_addr", {8'h0, bif.bus_address}, 32'd0);
    chk("midrst_rsp", {bif.rsp_rdata, bif.rsp_status, bif.rsp_valid, 5'b0, bif.rsp_err, bif.rsp_timeout}, 32'd0);
    chk("midrst_ready", {31'b0, bif.cmd_ready}, 32'd1);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_cleanup", log_q.size(), 32'd3);
    rd_vals = '{16'h7E81};
    run_op(2'b00, 22'h01F00, 16'h0000, -1);

    for (int t = 0; t < 16; t++) begin
      logic [1:0] op;
      int         k;
      op = 2'($urandom_range(3));
      rd_vals.delete();
      if (op == 2'b00) rd_vals.push_back(16'($urandom()));
      else if (op == 2'b11) rd_vals.push_back(16'($urandom()) & 16'hFFC5);
      else begin
        k = $urandom_range(5);
        for (int j = 0; j < k; j++) rd_vals.push_back(16'($urandom()) & 16'hFF7F);
        rd_vals.push_back(16'($urandom()) | 16'h0080);
      end
      run_op(op, 22'($urandom()), 16'($urandom()), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
